// File: rtl/video_timing_pkg.sv
// Shared raster timing sets, counter width and RGB888 colour constants for
// the HDMI colour-bar path (timing generator and pixel generator).
package video_timing_pkg;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [23:0]      rgb_t;

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
  localparam cnt_t H_SYNC_720P  = 12'd40;
  localparam cnt_t H_BACK_720P  = 12'd220;
  localparam cnt_t H_DISP_720P  = 12'd1280;
  localparam cnt_t H_TOTAL_720P = 12'd1650;
  localparam cnt_t V_SYNC_720P  = 12'd5;
  localparam cnt_t V_BACK_720P  = 12'd20;
  localparam cnt_t V_DISP_720P  = 12'd720;
  localparam cnt_t V_TOTAL_720P = 12'd750;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam cnt_t H_SYNC_480P  = 12'd96;
  localparam cnt_t H_BACK_480P  = 12'd48;
  localparam cnt_t H_DISP_480P  = 12'd640;
  localparam cnt_t H_TOTAL_480P = 12'd800;
  localparam cnt_t V_SYNC_480P  = 12'd2;
  localparam cnt_t V_BACK_480P  = 12'd33;
  localparam cnt_t V_DISP_480P  = 12'd480;
  localparam cnt_t V_TOTAL_480P = 12'd525;

  // 1920x1080 @ 60 Hz, 148.5 MHz pixel clock
  localparam cnt_t H_SYNC_1080P  = 12'd44;
  localparam cnt_t H_BACK_1080P  = 12'd148;
  localparam cnt_t H_DISP_1080P  = 12'd1920;
  localparam cnt_t H_TOTAL_1080P = 12'd2200;
  localparam cnt_t V_SYNC_1080P  = 12'd5;
  localparam cnt_t V_BACK_1080P  = 12'd36;
  localparam cnt_t V_DISP_1080P  = 12'd1080;
  localparam cnt_t V_TOTAL_1080P = 12'd1125;

  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_BLACK   = 24'h000000;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;

endpackage

// File: rtl/video_timing_cnt.sv
// Wrap counter: counts 0..LAST while enabled; carry is high on the enabled
// cycle that wraps back to zero.
module video_timing_cnt #(
  parameter int           W    = 12,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         carry
);

  assign carry = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (carry) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_driver.sv
// Raster timing generator: free-running h/v counters, registered sync/DE,
// pixel request coordinates one cycle ahead of DE, and DE-gated RGB output.
module video_driver
  import video_timing_pkg::*;
#(
  parameter cnt_t H_SYNC  = H_SYNC_720P,
  parameter cnt_t H_BACK  = H_BACK_720P,
  parameter cnt_t H_DISP  = H_DISP_720P,
  parameter cnt_t H_TOTAL = H_TOTAL_720P,
  parameter cnt_t V_SYNC  = V_SYNC_720P,
  parameter cnt_t V_BACK  = V_BACK_720P,
  parameter cnt_t V_DISP  = V_DISP_720P,
  parameter cnt_t V_TOTAL = V_TOTAL_720P
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam cnt_t H_ACT_START = H_SYNC + H_BACK;
  localparam cnt_t H_ACT_END   = H_ACT_START + H_DISP;
  localparam cnt_t V_ACT_START = V_SYNC + V_BACK;
  localparam cnt_t V_ACT_END   = V_ACT_START + V_DISP;

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_carry;
  logic v_carry;
  logic at_origin;
  logic h_act;
  logic v_act;
  logic data_req;

  video_timing_cnt #(.W(CNT_W), .LAST(H_TOTAL - 12'd1)) u_h_cnt (
    .clk   (pixel_clk),
    .rst   (sys_rst),
    .en    (1'b1),
    .cnt   (h_cnt),
    .carry (h_carry)
  );

  video_timing_cnt #(.W(CNT_W), .LAST(V_TOTAL - 12'd1)) u_v_cnt (
    .clk   (pixel_clk),
    .rst   (sys_rst),
    .en    (h_carry),
    .cnt   (v_cnt),
    .carry (v_carry)
  );

  assign h_act    = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
  assign v_act    = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  assign data_req = h_act && v_act;

  assign pixel_xpos = data_req ? 11'(h_cnt - H_ACT_START) : 11'd0;
  assign pixel_ypos = data_req ? 11'(v_cnt - V_ACT_START) : 11'd0;

  // at_origin tracks (h_cnt == 0 && v_cnt == 0): reset puts the counters at
  // the origin, and afterwards they return there only on a joint h/v wrap.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      at_origin   <= 1'b1;
      video_hs    <= 1'b0;
      video_vs    <= 1'b0;
      video_de    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      at_origin   <= h_carry && v_carry;
      video_hs    <= (h_cnt < H_SYNC);
      video_vs    <= (v_cnt < V_SYNC);
      video_de    <= data_req;
      frame_start <= at_origin;
    end
  end

  assign video_rgb = video_de ? pixel_data : 24'd0;

endmodule

// File: tb/tb_video_driver.sv
// Directed bench: a 720p instance with a {xpos,ypos} echo stub and a small
// raster instance that makes whole frames and frame wrap affordable.
module tb_video_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stub_mode = 1'b0;
  logic [23:0] stub_q = 24'd0;
  logic [23:0] pixel_data;

  logic [10:0] xpos, ypos, xpos_s, ypos_s;
  logic        hs, vs, de, fs, hs_s, vs_s, de_s, fs_s;
  logic [23:0] rgb, rgb_s;

  always #5 clk = ~clk;

  // pixel generator stand-in: one register of latency, echoes the request
  always @(posedge clk) stub_q <= {2'b00, xpos, ypos};
  assign pixel_data = stub_mode ? stub_q : 24'hFFFFFF;

  video_driver dut (
    .pixel_clk(clk), .sys_rst(rst), .pixel_data(pixel_data),
    .pixel_xpos(xpos), .pixel_ypos(ypos), .video_hs(hs), .video_vs(vs),
    .video_de(de), .video_rgb(rgb), .frame_start(fs)
  );

  video_driver #(
    .H_SYNC(12'd4), .H_BACK(12'd6), .H_DISP(12'd16), .H_TOTAL(12'd30),
    .V_SYNC(12'd2), .V_BACK(12'd3), .V_DISP(12'd8),  .V_TOTAL(12'd16)
  ) dut_s (
    .pixel_clk(clk), .sys_rst(rst), .pixel_data(24'hFFFFFF),
    .pixel_xpos(xpos_s), .pixel_ypos(ypos_s), .video_hs(hs_s), .video_vs(vs_s),
    .video_de(de_s), .video_rgb(rgb_s), .frame_start(fs_s)
  );

  int total = 0;
  int bad = 0;
  int cyc;
  int hs_run, last_hs_run, hs_rise, prev_hs_rise, hs_fall, hs_low;
  int de_run, last_de_run, de_rise, vs_run, last_vs_run, vs_s_run, last_vs_s_run;
  int fs_cnt, fs_s_cnt, fs_s_second, de_s_frame, gate_bad;
  logic prev_hs, prev_de, prev_vs, prev_vs_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},   {24'd0, hs, vs, de, fs, hs_s, vs_s, de_s, fs_s}, 32'd0);
    check({tag, "_pos"},   {10'd0, xpos, ypos}, 32'd0);
    check({tag, "_rgb"},   {8'd0, rgb}, 32'd0);
    check({tag, "_pos_s"}, {10'd0, xpos_s, ypos_s}, 32'd0);
    check({tag, "_rgb_s"}, {8'd0, rgb_s}, 32'd0);
  endtask

  task automatic hold_reset(input string tag);
    repeat (5) begin
      @(negedge clk);
      check_zero(tag);
    end
    rst = 1'b0;
  endtask

  // cyc counts rising edges since reset release; the counters hold cyc there
  task automatic run_raster(input int last);
    cyc = 0;
    hs_run = 0; last_hs_run = 0; hs_rise = 0; prev_hs_rise = 0; hs_fall = 0; hs_low = 0;
    de_run = 0; last_de_run = 0; de_rise = 0; vs_run = 0; last_vs_run = 0;
    vs_s_run = 0; last_vs_s_run = 0;
    fs_cnt = 0; fs_s_cnt = 0; fs_s_second = 0; de_s_frame = 0; gate_bad = 0;
    prev_hs = 1'b0; prev_de = 1'b0; prev_vs = 1'b0; prev_vs_s = 1'b0;
    while (cyc < last) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("edge1_ctl", {hs, vs, fs, de, hs_s, vs_s, fs_s, de_s}, 8'b1110_1110);
      if (cyc == 2) begin
        check("edge2_fs", {fs, fs_s}, 2'b00);
        check("edge2_hs", {hs, hs_s}, 2'b11);
      end
      if (hs && !prev_hs) begin
        prev_hs_rise = hs_rise; hs_rise = cyc; hs_low = cyc - hs_fall;
      end
      if (!hs && prev_hs) begin last_hs_run = hs_run; hs_fall = cyc; end
      hs_run = hs ? hs_run + 1 : 0;
      if (de && !prev_de) de_rise = cyc;
      if (!de && prev_de) last_de_run = de_run;
      de_run = de ? de_run + 1 : 0;
      if (!vs && prev_vs) last_vs_run = vs_run;
      vs_run = vs ? vs_run + 1 : 0;
      if (!vs_s && prev_vs_s) last_vs_s_run = vs_s_run;
      vs_s_run = vs_s ? vs_s_run + 1 : 0;
      if (fs) fs_cnt++;
      if (fs_s) begin
        fs_s_cnt++;
        if (fs_s_cnt == 2) fs_s_second = cyc;
      end
      if (de_s && cyc <= 480) de_s_frame++;
      if (!de && rgb != 24'd0) gate_bad++;
      if (rgb_s !== (de_s ? 24'hFFFFFF : 24'd0)) gate_bad++;
      prev_hs = hs; prev_de = de; prev_vs = vs; prev_vs_s = vs_s;
      case (cyc)
        160:   check("s_first_px", {10'd0, xpos_s, ypos_s}, {10'd0, 11'd0, 11'd0});
        161:   check("s_first_de", {7'd0, de_s, rgb_s}, {7'd0, 1'b1, 24'hFFFFFF});
        175:   check("s_last_col", {10'd0, xpos_s, ypos_s}, {10'd0, 11'd15, 11'd0});
        176:   check("s_past_col", {10'd0, xpos_s, ypos_s}, 32'd0);
        385:   check("s_last_px",  {10'd0, xpos_s, ypos_s}, {10'd0, 11'd15, 11'd7});
        400:   check("s_blank_ln", {9'd0, de_s, xpos_s, ypos_s}, 32'd0);
        41510: check("px_260_25",  {9'd0, de, xpos, ypos}, 32'd0);
        41511: check("px_261_25",  {de, xpos, ypos, rgb[8:0]}, {1'b1, 11'd1, 11'd0, 9'd0});
        41512: check("rgb_261",    {7'd0, de, rgb}, {7'd0, 1'b1, 24'h000800});
        44439: check("px_1539_26", {10'd0, xpos, ypos}, {10'd0, 11'd1279, 11'd1});
        44440: begin
          check("px_1540_26", {10'd0, xpos, ypos}, 32'd0);
          check("rgb_1539",   {7'd0, de, rgb}, {7'd0, 1'b1, 24'h27F801});
        end
        44441: check("rgb_off",    {7'd0, de, rgb}, 32'd0);
        default: ;
      endcase
      if (cyc == 41250) stub_mode = 1'b1;
    end
  endtask

  initial begin
    hold_reset("rst1");
    run_raster(45450);
    check("hs_high_len",   last_hs_run, 40);
    check("hs_low_len",    hs_low, 1610);
    check("line_period",   hs_rise - prev_hs_rise, 1650);
    check("hs_rise_phase", hs_rise % 1650, 1);
    check("de_rise_phase", de_rise % 1650, 261);
    check("de_high_len",   last_de_run, 1280);
    check("vs_high_len",   last_vs_run, 8250);
    check("fs_count",      fs_cnt, 1);
    check("gate_bad",      gate_bad, 0);
    check("s_fs_second",   fs_s_second, 481);
    check("s_fs_count",    fs_s_cnt, 95);
    check("s_vs_len",      last_vs_s_run, 60);
    check("s_de_frame",    de_s_frame, 128);

    // mid-line reset at h=900 of line 27, away from any clock edge
    check("pre_rst_de",  {31'd0, de}, 32'd1);
    check("pre_rst_pos", {10'd0, xpos, ypos}, {10'd0, 11'd640, 11'd2});
    check("pre_rst_rgb", {8'd0, rgb}, {8'd0, 24'h13F802});
    #2 rst = 1'b1;
    stub_mode = 1'b0;
    #1 check_zero("async_rst");
    hold_reset("rst2");
    run_raster(500);
    check("r2_fs_second", fs_s_second, 481);
    check("r2_fs_count",  fs_cnt, 1);
    check("r2_gate_bad",  gate_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
